// File: rtl/seq_result_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_result_packer: packs detected nibbles into 16-bit words, 4-deep FIFO  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seq_result_packer #(
   parameter int TIMEOUT = 8
) (
   input  logic        SYSCLK,
   input  logic        RST_B,
   input  logic        IN_VALID,
   input  logic [3:0]  DATA_IN,
   input  logic        FLUSH,
   input  logic        CLR_OVF,
   input  logic        OUT_READY,
   output logic        OUT_VALID,
   output logic [15:0] DATA_OUT,
   output logic [2:0]  OUT_CNT,
   output logic [2:0]  FIFO_LEVEL,
   output logic        OVERFLOW
);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      STALL   = 1'b1
   } state_t;

   localparam logic [3:0] IDLE_LAST = 4'(TIMEOUT - 1);
   localparam logic [2:0] FIFO_DEPTH = 3'd4;

   state_t      state, state_nxt;
   logic [15:0] word, word_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [3:0]  idle, idle_nxt;
   logic        ovf, ovf_nxt;

   logic [15:0] fifo_data [4];
   logic [2:0]  fifo_cnt  [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  level;

   logic        pop, space, push, drop, commit;
   logic [15:0] push_word, acc_word;
   logic [2:0]  push_cnt, acc_cnt;

   assign pop   = (level != 3'd0) && OUT_READY;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign space = (level != FIFO_DEPTH) || pop;

   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      cnt_nxt   = cnt;
      idle_nxt  = idle;
      push      = 1'b0;
      push_word = word;
      push_cnt  = cnt;
      drop      = 1'b0;
      commit    = 1'b0;
      acc_word  = word;
      acc_cnt   = cnt;
      case (state)
         COLLECT: begin
            if (IN_VALID) begin
               acc_word = word | ({12'd0, DATA_IN} << {cnt[1:0], 2'b00});
               acc_cnt  = cnt + 3'd1;
               idle_nxt = 4'd0;
            end else if (cnt != 3'd0) begin
               idle_nxt = idle + 4'd1;
            end
            commit = (acc_cnt == 3'd4)
                  || (FLUSH && (acc_cnt != 3'd0))
                  || (!IN_VALID && (cnt != 3'd0) && (idle == IDLE_LAST));
            word_nxt = acc_word;
            cnt_nxt  = acc_cnt;
            if (commit) begin
               idle_nxt = 4'd0;
               if (space) begin
                  push      = 1'b1;
                  push_word = acc_word;
                  push_cnt  = acc_cnt;
                  word_nxt  = 16'd0;
                  cnt_nxt   = 3'd0;
               end else begin
                  // word/cnt keep the committed word until the FIFO frees up
                  state_nxt = STALL;
               end
            end
         end
         STALL: begin
            drop = IN_VALID;
            if (space) begin
               push      = 1'b1;
               word_nxt  = 16'd0;
               cnt_nxt   = 3'd0;
               state_nxt = COLLECT;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
      ovf_nxt = (ovf && !CLR_OVF) || drop;
   end

   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         state <= COLLECT;
         word  <= 16'd0;
         cnt   <= 3'd0;
         idle  <= 4'd0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         word  <= word_nxt;
         cnt   <= cnt_nxt;
         idle  <= idle_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         for (int i = 0; i < 4; i++) begin
            fifo_data[i] <= 16'd0;
            fifo_cnt[i]  <= 3'd0;
         end
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         level  <= 3'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= push_word;
            fifo_cnt[wr_ptr]  <= push_cnt;
            wr_ptr            <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         level <= level + {2'd0, push} - {2'd0, pop};
      end
   end

   assign OUT_VALID  = (level != 3'd0);
   assign DATA_OUT   = OUT_VALID ? fifo_data[rd_ptr] : 16'd0;
   assign OUT_CNT    = OUT_VALID ? fifo_cnt[rd_ptr]  : 3'd0;
   assign FIFO_LEVEL = level;
   assign OVERFLOW   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_result_packer.sv
`default_nettype none
// Testbench for seq_result_packer: directed scenarios plus randomized traffic
// checked against a queue-based model of the packing rules.
module tb_seq_result_packer;

   localparam int TB_TIMEOUT = 8;

   logic        SYSCLK = 1'b0;
   logic        RST_B = 1'b1;
   logic        IN_VALID = 1'b0;
   logic [3:0]  DATA_IN = 4'd0;
   logic        FLUSH = 1'b0;
   logic        CLR_OVF = 1'b0;
   logic        OUT_READY = 1'b0;
   logic        OUT_VALID;
   logic [15:0] DATA_OUT;
   logic [2:0]  OUT_CNT;
   logic [2:0]  FIFO_LEVEL;
   logic        OVERFLOW;

   int n_checks = 0;
   int n_pass = 0;

   seq_result_packer #(.TIMEOUT(TB_TIMEOUT)) dut (
      .SYSCLK(SYSCLK), .RST_B(RST_B), .IN_VALID(IN_VALID), .DATA_IN(DATA_IN),
      .FLUSH(FLUSH), .CLR_OVF(CLR_OVF), .OUT_READY(OUT_READY),
      .OUT_VALID(OUT_VALID), .DATA_OUT(DATA_OUT), .OUT_CNT(OUT_CNT),
      .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW)
   );

   always #5 SYSCLK = ~SYSCLK;

   // Reference model: held nibbles, a stalled word, and the FIFO as a queue
   // of {count, data} entries.
   int          held[$];
   int          idle_m;
   bit          stalled;
   logic [18:0] stall_e;
   logic [18:0] fifo_m[$];
   bit          ovf_m;

   function automatic logic [18:0] pack_held();
      logic [15:0] w = 16'd0;
      foreach (held[i]) w = w | (16'(held[i]) << (4 * i));
      return {3'(held.size()), w};
   endfunction

   task automatic model_reset();
      held.delete();
      fifo_m.delete();
      idle_m = 0;
      stalled = 0;
      stall_e = '0;
      ovf_m = 0;
   endtask

   task automatic model_step(input bit iv, input int d, input bit fl, input bit co, input bit rdy);
      bit pop, space, drop, push;
      logic [18:0] e = '0;
      pop = (fifo_m.size() != 0) && rdy;
      space = (fifo_m.size() < 4) || pop;
      drop = 0;
      push = 0;
      if (stalled) begin
         drop = iv;
         if (space) begin
            push = 1;
            e = stall_e;
            stalled = 0;
         end
      end else begin
         if (iv) begin
            held.push_back(d);
            idle_m = 0;
         end else if (held.size() > 0) begin
            idle_m++;
         end
         if (held.size() == 4 || (fl && held.size() > 0) || (held.size() > 0 && idle_m >= TB_TIMEOUT)) begin
            e = pack_held();
            held.delete();
            idle_m = 0;
            if (space) push = 1;
            else begin
               stalled = 1;
               stall_e = e;
            end
         end
      end
      if (pop) void'(fifo_m.pop_front());
      if (push) fifo_m.push_back(e);
      ovf_m = (ovf_m && !co) || drop;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit iv, input logic [3:0] d, input bit fl, input bit co, input bit rdy);
      IN_VALID = iv;
      DATA_IN = d;
      FLUSH = fl;
      CLR_OVF = co;
      OUT_READY = rdy;
      @(posedge SYSCLK);
      model_step(iv, int'(d), fl, co, rdy);
      @(negedge SYSCLK);
      IN_VALID = 0;
      FLUSH = 0;
      CLR_OVF = 0;
   endtask

   task automatic test_reset();
      #1 RST_B = 1'b0;
      #1;
      n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", OUT_VALID); else n_pass++;
      n_checks++; if (DATA_OUT !== 16'h0) $display("FAIL reset_data: got %h want 0000", DATA_OUT); else n_pass++;
      n_checks++; if (OUT_CNT !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", OUT_CNT); else n_pass++;
      n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); else n_pass++;
      n_checks++; if (OVERFLOW !== 1'b0) $display("FAIL reset_ovf: got %b want 0", OVERFLOW); else n_pass++;
      model_reset();
      repeat (2) @(negedge SYSCLK);
      RST_B = 1'b1;
   endtask

   task automatic test_full_word();
      for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 0, 0, 1);
      n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL full_valid: got %b want 1", OUT_VALID); else n_pass++;
      n_checks++; if (DATA_OUT !== 16'h4321) $display("FAIL full_data: got %h want 4321", DATA_OUT); else n_pass++;
      n_checks++; if (OUT_CNT !== 3'd4) $display("FAIL full_cnt: got %0d want 4", OUT_CNT); else n_pass++;
      cycle(0, 0, 0, 0, 1);
      n_checks++; if (FIFO_LEVEL !== 3'd0 || OUT_VALID !== 1'b0)
         $display("FAIL full_pop: got level %0d valid %b want 0 0", FIFO_LEVEL, OUT_VALID); else n_pass++;
   endtask

   task automatic test_timeout();
      cycle(1, 4'h5, 0, 0, 0);
      cycle(1, 4'h6, 0, 0, 0);
      repeat (TB_TIMEOUT - 1) cycle(0, 0, 0, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL timeout_early: got level %0d want 0", FIFO_LEVEL); else n_pass++;
      cycle(0, 0, 0, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd1) $display("FAIL timeout_level: got %0d want 1", FIFO_LEVEL); else n_pass++;
      n_checks++; if (DATA_OUT !== 16'h0065 || OUT_CNT !== 3'd2)
         $display("FAIL timeout_word: got %h/%0d want 0065/2", DATA_OUT, OUT_CNT); else n_pass++;
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_flush();
      cycle(1, 4'h9, 1, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd1 || DATA_OUT !== 16'h0009 || OUT_CNT !== 3'd1)
         $display("FAIL flush_word: got level %0d %h/%0d want 1 0009/1", FIFO_LEVEL, DATA_OUT, OUT_CNT); else n_pass++;
      cycle(0, 0, 1, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd1 || DATA_OUT !== 16'h0009)
         $display("FAIL flush_empty_held: got level %0d %h want 1 0009", FIFO_LEVEL, DATA_OUT); else n_pass++;
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL flush_noop: got level %0d want 0", FIFO_LEVEL); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [15:0] exp_heads[5] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};
      for (int i = 0; i < 20; i++) cycle(1, 4'(i % 16), 0, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd4 || DATA_OUT !== 16'h3210 || OVERFLOW !== 1'b0)
         $display("FAIL ovf_full: got level %0d %h ovf %b want 4 3210 0", FIFO_LEVEL, DATA_OUT, OVERFLOW); else n_pass++;
      cycle(1, 4'h7, 0, 0, 0);
      n_checks++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_set: got %b want 1", OVERFLOW); else n_pass++;
      cycle(1, 4'h8, 0, 1, 0);
      n_checks++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_clr_vs_drop: got %b want 1", OVERFLOW); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (DATA_OUT !== exp_heads[k])
            $display("FAIL ovf_drain_%0d: got %h want %h", k, DATA_OUT, exp_heads[k]); else n_pass++;
         cycle(0, 0, 0, 0, 1);
         if (k == 0) begin
            n_checks++; if (FIFO_LEVEL !== 3'd4) $display("FAIL ovf_stall_push: got level %0d want 4", FIFO_LEVEL); else n_pass++;
         end
      end
      n_checks++; if (FIFO_LEVEL !== 3'd0) $display("FAIL ovf_empty: got level %0d want 0", FIFO_LEVEL); else n_pass++;
      cycle(0, 0, 0, 1, 0);
      n_checks++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clear: got %b want 0", OVERFLOW); else n_pass++;
   endtask

   task automatic test_simul_push_pop();
      logic [15:0] exp_heads[4] = '{16'h7654, 16'hBA98, 16'hFEDC, 16'hA210};
      for (int i = 0; i < 19; i++) cycle(1, 4'(i % 16), 0, 0, 0);
      cycle(1, 4'hA, 0, 0, 1);
      n_checks++; if (FIFO_LEVEL !== 3'd4 || OVERFLOW !== 1'b0)
         $display("FAIL pushpop_level: got level %0d ovf %b want 4 0", FIFO_LEVEL, OVERFLOW); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (DATA_OUT !== exp_heads[k])
            $display("FAIL pushpop_drain_%0d: got %h want %h", k, DATA_OUT, exp_heads[k]); else n_pass++;
         cycle(0, 0, 0, 0, 1);
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 11; i++) cycle(1, 4'(i + 1), 0, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd2) $display("FAIL midrst_pre: got level %0d want 2", FIFO_LEVEL); else n_pass++;
      #2 RST_B = 1'b0;
      #1;
      n_checks++; if ({OUT_VALID, DATA_OUT, OUT_CNT, FIFO_LEVEL, OVERFLOW} !== 24'd0)
         $display("FAIL midrst_outputs: got %b %h %0d %0d %b want all 0",
                  OUT_VALID, DATA_OUT, OUT_CNT, FIFO_LEVEL, OVERFLOW); else n_pass++;
      model_reset();
      @(negedge SYSCLK);
      RST_B = 1'b1;
      cycle(1, 4'h7, 1, 0, 0);
      n_checks++; if (FIFO_LEVEL !== 3'd1 || OUT_CNT !== 3'd1 || DATA_OUT !== 16'h0007)
         $display("FAIL midrst_after: got level %0d %h/%0d want 1 0007/1", FIFO_LEVEL, DATA_OUT, OUT_CNT); else n_pass++;
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      int p_in = 50;
      int p_rdy = 80;
      logic [23:0] exp_v;
      for (int c = 0; c < 800; c++) begin
         if (c % 50 == 0) begin
            p_in = (c % 150 == 0) ? 8 : ((c % 150 == 50) ? 60 : 95);
            p_rdy = (c % 200 < 100) ? 90 : 15;
         end
         cycle($urandom_range(0, 99) < p_in, 4'($urandom), $urandom_range(0, 99) < 5,
               $urandom_range(0, 99) < 5, $urandom_range(0, 99) < p_rdy);
         exp_v = {fifo_m.size() != 0,
                  (fifo_m.size() != 0) ? fifo_m[0][15:0] : 16'h0,
                  (fifo_m.size() != 0) ? fifo_m[0][18:16] : 3'd0,
                  3'(fifo_m.size()), ovf_m};
         n_checks++;
         if ({OUT_VALID, DATA_OUT, OUT_CNT, FIFO_LEVEL, OVERFLOW} !== exp_v)
            $display("FAIL random_c%0d: got v%b d%h c%0d l%0d o%b want v%b d%h c%0d l%0d o%b", c,
                     OUT_VALID, DATA_OUT, OUT_CNT, FIFO_LEVEL, OVERFLOW,
                     exp_v[23], exp_v[22:7], exp_v[6:4], exp_v[3:1], exp_v[0]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_timeout();
      test_flush();
      test_overflow();
      test_simul_push_pop();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
